rggen_bus_initiator: RTL and testbench

- Host-side driver for rggen_bus_if: accepts read/write commands on a local valid/ready port and issues them one at a time as bus transactions through the bus_if.master modport.
- Returns status, read data and measured latency on a response port with backpressure.
- Used by test sequencers, boot/init engines and bridge front-ends that must initiate register accesses toward a register-block adapter.

---
 rtl/rggen_rtl_pkg.sv | 12 +
 rtl/rggen_bus_if.sv | 38 +++
 rtl/rggen_bus_initiator_buffer.sv | 37 +++
 rtl/rggen_bus_initiator.sv | 151 +++++++++++++++
 tb/tb_rggen_bus_initiator.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus definitions: response status encodings seen on rggen_bus_if.
package rggen_rtl_pkg;

  // Completion status returned by a register-block adapter.
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

endpackage

// File: rtl/rggen_bus_if.sv
// Register bus between an initiator (master) and a register-block adapter (slave).
interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32
) ();

  logic                         valid;
  logic                         write;
  logic [ADDRESS_WIDTH-1:0]     address;
  logic [BUS_WIDTH-1:0]         write_data;
  logic [BUS_WIDTH/8-1:0]       strobe;
  logic                         ready;
  rggen_rtl_pkg::rggen_status   status;
  logic [BUS_WIDTH-1:0]         read_data;

  modport master (
    output valid,
    output write,
    output address,
    output write_data,
    output strobe,
    input  ready,
    input  status,
    input  read_data
  );

  modport slave (
    input  valid,
    input  write,
    input  address,
    input  write_data,
    input  strobe,
    output ready,
    output status,
    output read_data
  );

endinterface

// File: rtl/rggen_bus_initiator_buffer.sv
// One-entry valid/ready holding register. A push is accepted while the entry is
// empty or being popped in the same cycle, so a full entry can be replaced
// without a bubble.
module rggen_bus_initiator_buffer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic             full_reg;
  logic [WIDTH-1:0] data_reg;

  assign push_ready = !full_reg || pop_ready;
  assign pop_valid  = full_reg;
  assign pop_data   = data_reg;

  // Entry occupancy and payload; a simultaneous push and pop keeps it full with the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (push_valid && push_ready) begin
      full_reg <= 1'b1;
      data_reg <= push_data;
    end else if (pop_ready) begin
      full_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/rggen_bus_initiator.sv
// Host-side register-bus initiator: buffers one command, runs it as a single
// bus transaction, and returns status, read data and cycle latency on a
// backpressured response port.
module rggen_bus_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int LATENCY_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_resp_valid,
  input  logic                     i_resp_ready,
  output rggen_status              o_resp_status,
  output logic [BUS_WIDTH-1:0]     o_resp_read_data,
  output logic [LATENCY_WIDTH-1:0] o_resp_latency,
  rggen_bus_if.master              bus_if
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int RESP_WIDTH   = 2 + BUS_WIDTH + LATENCY_WIDTH;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  typedef struct packed {
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [STROBE_WIDTH-1:0]  strobe;
  } cmd_t;

  localparam int CMD_WIDTH = $bits(cmd_t);

  // Command path
  cmd_t                     cmd_in;
  cmd_t                     cmd_head;
  logic                     cmd_full;
  logic                     cmd_launch;

  // Bus request side
  state_t                   state_reg;
  logic                     bus_valid_reg;
  cmd_t                     bus_cmd_reg;
  logic [LATENCY_WIDTH-1:0] latency_reg;
  logic                     bus_done;

  // Response path
  logic                     resp_push_ready;
  logic                     resp_push_valid;
  logic [BUS_WIDTH-1:0]     captured_read_data;
  logic [RESP_WIDTH-1:0]    resp_in;
  logic [RESP_WIDTH-1:0]    resp_out;

  assign cmd_in = '{
    write:      i_cmd_write,
    address:    i_cmd_address,
    write_data: i_cmd_write_data,
    strobe:     i_cmd_strobe
  };

  // A launch needs a buffered command and a response slot that is empty or
  // emptying this cycle, so a completed transaction always has room to land.
  assign cmd_launch = (state_reg == IDLE) && cmd_full && (!o_resp_valid || i_resp_ready);

  rggen_bus_initiator_buffer #(
    .WIDTH (CMD_WIDTH)
  ) u_cmd_buffer (
    .clk        (i_clk),
    .rst        (i_rst),
    .push_valid (i_cmd_valid),
    .push_ready (o_cmd_ready),
    .push_data  (cmd_in),
    .pop_valid  (cmd_full),
    .pop_ready  (cmd_launch),
    .pop_data   (cmd_head)
  );

  // Request FSM: loads the bus registers on launch, holds them until ready,
  // and counts valid cycles with saturation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      bus_valid_reg <= 1'b0;
      bus_cmd_reg   <= '0;
      latency_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_launch) begin
            state_reg     <= REQ;
            bus_valid_reg <= 1'b1;
            bus_cmd_reg   <= cmd_head;
            latency_reg   <= LATENCY_WIDTH'(1);
          end
        end
        REQ: begin
          if (bus_if.ready) begin
            state_reg     <= IDLE;
            bus_valid_reg <= 1'b0;
          end else if (latency_reg != '1) begin
            latency_reg <= latency_reg + LATENCY_WIDTH'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          bus_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.valid      = bus_valid_reg;
  assign bus_if.write      = bus_cmd_reg.write;
  assign bus_if.address    = bus_cmd_reg.address;
  assign bus_if.write_data = bus_cmd_reg.write_data;
  assign bus_if.strobe     = bus_cmd_reg.strobe;

  assign bus_done           = (state_reg == REQ) && bus_if.ready;
  assign captured_read_data = bus_cmd_reg.write ? '0 : bus_if.read_data;
  assign resp_in            = {bus_if.status, captured_read_data, latency_reg};
  // The launch condition guarantees the slot can take this push.
  assign resp_push_valid    = bus_done && resp_push_ready;

  rggen_bus_initiator_buffer #(
    .WIDTH (RESP_WIDTH)
  ) u_resp_buffer (
    .clk        (i_clk),
    .rst        (i_rst),
    .push_valid (resp_push_valid),
    .push_ready (resp_push_ready),
    .push_data  (resp_in),
    .pop_valid  (o_resp_valid),
    .pop_ready  (i_resp_ready),
    .pop_data   (resp_out)
  );

  assign o_resp_status    = rggen_status'(resp_out[RESP_WIDTH-1 -: 2]);
  assign o_resp_read_data = resp_out[LATENCY_WIDTH +: BUS_WIDTH];
  assign o_resp_latency   = resp_out[LATENCY_WIDTH-1:0];

endmodule

// File: tb/tb_rggen_bus_initiator.sv
// Bench for rggen_bus_initiator: directed scenarios plus a randomized run,
// checked against a transaction-level model of expected bus and response traffic.
module tb_rggen_bus_initiator;
  import rggen_rtl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_address = '0;
  logic [31:0] cmd_write_data = '0;
  logic [3:0]  cmd_strobe = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  rggen_status resp_status;
  logic [31:0] resp_read_data;
  logic [7:0]  resp_latency;

  // Saturation DUT signals
  logic        s_cmd_valid = 1'b0;
  logic        s_cmd_ready;
  logic        s_cmd_write = 1'b0;
  logic [7:0]  s_cmd_address = '0;
  logic [31:0] s_cmd_write_data = '0;
  logic [3:0]  s_cmd_strobe = '0;
  logic        s_resp_valid;
  logic        s_resp_ready = 1'b1;
  rggen_status s_resp_status;
  logic [31:0] s_resp_read_data;
  logic [3:0]  s_resp_latency;

  rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bif ();
  rggen_bus_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32)) sbif ();

  rggen_bus_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .LATENCY_WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_address(cmd_address), .i_cmd_write_data(cmd_write_data), .i_cmd_strobe(cmd_strobe),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_status(resp_status),
    .o_resp_read_data(resp_read_data), .o_resp_latency(resp_latency),
    .bus_if(bif.master)
  );

  rggen_bus_initiator #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .LATENCY_WIDTH(4)) dut_sat (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(s_cmd_valid), .o_cmd_ready(s_cmd_ready), .i_cmd_write(s_cmd_write),
    .i_cmd_address(s_cmd_address), .i_cmd_write_data(s_cmd_write_data), .i_cmd_strobe(s_cmd_strobe),
    .o_resp_valid(s_resp_valid), .i_resp_ready(s_resp_ready), .o_resp_status(s_resp_status),
    .o_resp_read_data(s_resp_read_data), .o_resp_latency(s_resp_latency),
    .bus_if(sbif.master)
  );

  typedef struct {
    bit        w;
    bit [7:0]  a;
    bit [31:0] wd;
    bit [3:0]  st;
    int        wt;      // slave wait cycles before ready
    bit [1:0]  status;
    bit [31:0] rd;
  } txn_t;

  typedef struct {
    bit        w;
    bit [7:0]  a;
    bit [31:0] wd;
    bit [3:0]  st;
    int        cycles;
    bit        stable;
  } bus_obs_t;

  typedef struct {
    bit [1:0]  status;
    bit [31:0] rd;
    bit [7:0]  lat;
  } resp_obs_t;

  typedef struct {
    bit valid;
    bit cmd_ready;
  } cyc_t;

  typedef struct {
    int        cycles;
    bit [3:0]  lat;
    bit [1:0]  status;
    bit [31:0] rd;
  } sat_obs_t;

  txn_t      plan_q[$];   // written by main, consumed in order by the slave
  txn_t      exp_q[$];    // expected transactions (model)
  bus_obs_t  obs_bus[$];
  resp_obs_t obs_resp[$];
  cyc_t      cyc_log[$];
  sat_obs_t  s_obs[$];

  int n_cmp = 0;
  int n_mis = 0;
  int bus_rd = 0;
  int resp_rd = 0;
  bit rnd_rr = 1'b0;

  // Register-block adapter model for the main DUT; also logs per-cycle activity and responses.
  initial begin : slave_main
    int plan_rd;
    int scnt;
    bus_obs_t cur;
    plan_rd = 0;
    scnt = 0;
    cur = '{default: 0};
    bif.ready = 1'b0;
    bif.status = RGGEN_OKAY;
    bif.read_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        scnt = 0;
        bif.ready = 1'b0;
      end else if (bif.valid) begin
        if (scnt == 0) begin
          cur.w = bif.write; cur.a = bif.address; cur.wd = bif.write_data; cur.st = bif.strobe;
          cur.stable = 1'b1;
        end else if ({bif.write, bif.address, bif.write_data, bif.strobe} != {cur.w, cur.a, cur.wd, cur.st}) begin
          cur.stable = 1'b0;
        end
        if (plan_rd < plan_q.size() && scnt >= plan_q[plan_rd].wt) begin
          bif.ready = 1'b1;
          bif.status = rggen_status'(plan_q[plan_rd].status);
          bif.read_data = plan_q[plan_rd].rd;
          cur.cycles = scnt + 1;
          obs_bus.push_back(cur);
          plan_rd++;
          scnt = 0;
        end else begin
          bif.ready = 1'b0;
          bif.status = rggen_status'(2'($urandom_range(0, 3)));
          bif.read_data = $urandom;
          scnt++;
        end
      end else begin
        bif.ready = 1'b0;
      end
      cyc_log.push_back('{bif.valid, cmd_ready});
      if (!rst && resp_valid && resp_ready)
        obs_resp.push_back('{resp_status, resp_read_data, resp_latency});
    end
  end

  // Adapter model for the saturation DUT: ready after 20 low cycles.
  initial begin : slave_sat
    int scnt;
    int cyc;
    scnt = 0;
    cyc = 0;
    sbif.ready = 1'b0;
    sbif.status = RGGEN_OKAY;
    sbif.read_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        scnt = 0;
        sbif.ready = 1'b0;
      end else if (sbif.valid) begin
        if (scnt >= 20) begin
          sbif.ready = 1'b1;
          sbif.status = RGGEN_DECODE_ERROR;
          sbif.read_data = 32'h1234_5678;
          cyc = scnt + 1;
          scnt = 0;
        end else begin
          sbif.ready = 1'b0;
          scnt++;
        end
      end else begin
        sbif.ready = 1'b0;
      end
      if (!rst && s_resp_valid && s_resp_ready)
        s_obs.push_back('{cyc, s_resp_latency, s_resp_status, s_resp_read_data});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input txn_t t, input bit track);
    bit acc;
    acc = 1'b0;
    plan_q.push_back(t);
    if (track) exp_q.push_back(t);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = t.w;
    cmd_address = t.a;
    cmd_write_data = t.wd;
    cmd_strobe = t.st;
    for (int k = 0; k < 300; k++) begin
      if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
      #1;
      if (cmd_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) chk("cmd_accept_timeout", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resps(input int n, input int budget);
    for (int k = 0; k < budget && obs_resp.size() < n; k++) begin
      @(negedge clk);
      if (rnd_rr) resp_ready = 1'($urandom_range(0, 1));
    end
    chk("resp_count", 64'(obs_resp.size()), 64'(n));
  endtask

  // Compares every outstanding expected transaction against what the bus and response port showed.
  task automatic check_all(input string tag);
    txn_t e;
    bus_obs_t b;
    resp_obs_t r;
    bit [7:0] exp_lat;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_lat = (e.wt + 1 > 255) ? 8'd255 : 8'(e.wt + 1);
      if (bus_rd < obs_bus.size()) begin
        b = obs_bus[bus_rd];
        bus_rd++;
        chk({tag, "_bus_write"}, 64'(b.w), 64'(e.w));
        chk({tag, "_bus_addr"}, 64'(b.a), 64'(e.a));
        chk({tag, "_bus_wdata"}, 64'(b.wd), 64'(e.wd));
        chk({tag, "_bus_strobe"}, 64'(b.st), 64'(e.st));
        chk({tag, "_bus_cycles"}, 64'(b.cycles), 64'(e.wt + 1));
        chk({tag, "_bus_stable"}, 64'(b.stable), 64'd1);
      end else begin
        chk({tag, "_bus_missing"}, 64'(obs_bus.size()), 64'(bus_rd + 1));
      end
      if (resp_rd < obs_resp.size()) begin
        r = obs_resp[resp_rd];
        resp_rd++;
        chk({tag, "_resp_status"}, 64'(r.status), 64'(e.status));
        chk({tag, "_resp_rdata"}, 64'(r.rd), e.w ? 64'd0 : 64'(e.rd));
        chk({tag, "_resp_latency"}, 64'(r.lat), 64'(exp_lat));
      end else begin
        chk({tag, "_resp_missing"}, 64'(obs_resp.size()), 64'(resp_rd + 1));
      end
    end
  endtask

  initial begin : main
    txn_t t;
    int idx0;
    int f;
    bit [5:0] pat;
    int run;
    int maxrun;
    bit saw_ready;
    int nb0;
    int nr0;
    int vcount;
    bit acc;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_bus_valid", 64'(bif.valid), 64'd0);
    chk("rst_resp_status", 64'(resp_status), 64'd0);
    chk("rst_resp_rdata", 64'(resp_read_data), 64'd0);
    chk("rst_resp_latency", 64'(resp_latency), 64'd0);
    chk("rst_bus_addr", 64'(bif.address), 64'd0);
    chk("rst_sat_latency", 64'(s_resp_latency), 64'd0);
    rst = 1'b0;

    // Write completed in the first valid cycle
    t = '{w: 1'b1, a: 8'h10, wd: 32'hA5A5_0001, st: 4'hF, wt: 0, status: 2'b00, rd: 32'hCAFE_F00D};
    push_cmd(t, 1'b1);
    wait_resps(resp_rd + exp_q.size(), 100);
    check_all("wr_fast");

    // Read with three wait states returning SLAVE_ERROR
    t = '{w: 1'b0, a: 8'h24, wd: 32'h0, st: 4'hF, wt: 3, status: 2'b10, rd: 32'hDEAD_BEEF};
    push_cmd(t, 1'b1);
    wait_resps(resp_rd + exp_q.size(), 100);
    check_all("rd_wait");

    // Back-to-back with the response port always ready
    idx0 = cyc_log.size();
    for (int i = 0; i < 3; i++) begin
      t = '{w: 1'($urandom_range(0, 1)), a: 8'($urandom), wd: $urandom, st: 4'($urandom),
            wt: 0, status: 2'($urandom_range(0, 3)), rd: $urandom};
      push_cmd(t, 1'b1);
    end
    wait_resps(resp_rd + exp_q.size(), 100);
    repeat (2) @(negedge clk);
    f = -1;
    for (int i = idx0; i < cyc_log.size(); i++) begin
      if (cyc_log[i].valid && f < 0) f = i;
    end
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      if (f >= 0 && f + i < cyc_log.size()) pat[5-i] = cyc_log[f+i].valid;
    end
    chk("b2b_valid_pattern", 64'(pat), 64'b101010);
    maxrun = 0;
    run = 0;
    for (int i = idx0; i < cyc_log.size(); i++) begin
      run = cyc_log[i].cmd_ready ? 0 : run + 1;
      if (run > maxrun) maxrun = run;
    end
    chk("b2b_cmd_ready_low_gt1", 64'(maxrun > 1), 64'd0);
    check_all("b2b");

    // Response backpressure: one completes, second waits, third is refused
    resp_ready = 1'b0;
    nb0 = obs_bus.size();
    nr0 = obs_resp.size();
    for (int i = 0; i < 2; i++) begin
      t = '{w: 1'($urandom_range(0, 1)), a: 8'($urandom), wd: $urandom, st: 4'($urandom),
            wt: 0, status: 2'($urandom_range(0, 3)), rd: $urandom};
      push_cmd(t, 1'b1);
    end
    t = '{w: 1'b0, a: 8'h5C, wd: 32'h0, st: 4'h3, wt: 1, status: 2'b01, rd: $urandom};
    plan_q.push_back(t);
    exp_q.push_back(t);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = t.w;
    cmd_address = t.a;
    cmd_write_data = t.wd;
    cmd_strobe = t.st;
    saw_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (cmd_ready) saw_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    chk("bp_cmd_ready_seen", 64'(saw_ready), 64'd0);
    chk("bp_bus_completed", 64'(obs_bus.size() - nb0), 64'd1);
    chk("bp_resp_valid_held", 64'(resp_valid), 64'd1);
    chk("bp_bus_idle", 64'(bif.valid), 64'd0);
    chk("bp_no_pop", 64'(obs_resp.size() - nr0), 64'd0);
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    chk("bp_cmd_ready_on_pop", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_resps(resp_rd + exp_q.size(), 100);
    check_all("bp");

    // Randomized traffic with random response backpressure
    rnd_rr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      t = '{w: 1'($urandom_range(0, 1)), a: 8'($urandom), wd: $urandom, st: 4'($urandom),
            wt: $urandom_range(0, 4), status: 2'($urandom_range(0, 3)), rd: $urandom};
      push_cmd(t, 1'b1);
    end
    wait_resps(resp_rd + exp_q.size(), 3000);
    rnd_rr = 1'b0;
    resp_ready = 1'b1;
    check_all("rand");

    // Latency saturation on the 4-bit instance
    @(negedge clk);
    s_cmd_valid = 1'b1;
    s_cmd_write = 1'b0;
    s_cmd_address = 8'h33;
    s_cmd_strobe = 4'hF;
    acc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (s_cmd_ready) begin
        acc = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("sat_cmd_accept", 64'(acc), 64'd1);
    @(posedge clk);
    #1;
    s_cmd_valid = 1'b0;
    for (int k = 0; k < 100 && s_obs.size() < 1; k++) @(negedge clk);
    chk("sat_resp_count", 64'(s_obs.size()), 64'd1);
    if (s_obs.size() > 0) begin
      chk("sat_latency", 64'(s_obs[0].lat), 64'd15);
      chk("sat_bus_cycles", 64'(s_obs[0].cycles), 64'd21);
      chk("sat_status", 64'(s_obs[0].status), 64'(RGGEN_DECODE_ERROR));
      chk("sat_rdata", 64'(s_obs[0].rd), 64'h1234_5678);
    end

    // Reset during REQ with a second command buffered
    t = '{w: 1'b1, a: 8'h77, wd: 32'h1111_2222, st: 4'hA, wt: 10, status: 2'b00, rd: 32'h0};
    push_cmd(t, 1'b0);
    t = '{w: 1'b0, a: 8'h78, wd: 32'h0, st: 4'h5, wt: 0, status: 2'b00, rd: 32'h9};
    push_cmd(t, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_pre_bus_valid", 64'(bif.valid), 64'd1);
    chk("mid_pre_cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_bus_valid", 64'(bif.valid), 64'd0);
    chk("mid_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_cmd_ready", 64'(cmd_ready), 64'd1);
    rst = 1'b0;
    nb0 = obs_bus.size();
    nr0 = obs_resp.size();
    idx0 = cyc_log.size();
    repeat (20) @(negedge clk);
    #3;
    vcount = 0;
    for (int i = idx0; i < cyc_log.size(); i++) vcount += int'(cyc_log[i].valid);
    chk("mid_no_bus_after", 64'(vcount), 64'd0);
    chk("mid_no_bus_done", 64'(obs_bus.size() - nb0), 64'd0);
    chk("mid_no_resp", 64'(obs_resp.size() - nr0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
